// File: rtl/disp_fetch_pkg.sv
// Shared definitions for the display line-FIFO fetch arbiter: FSM encoding,
// default widths and the 1024x640 frame size.
package disp_fetch_pkg;

   localparam int DEF_ADDR_W = 24;
   localparam int DEF_LVL_W  = 11;
   localparam int DEF_LEN_W  = 8;
   localparam int REM_W      = 24;

   localparam int FRAME_WORDS_1024X640 = 1024 * 640;

   typedef enum logic [2:0] {
      IDLE,
      ARB,
      REQ,
      WAIT,
      DRAIN
   } fetch_state_t;

endpackage

// File: rtl/disp_fetch_layer_ctr.sv
// Per-layer frame address / remaining-word counters and fetch eligibility.
// The active flag latches layer_en at frame start and drops for the rest of the frame once the layer is disabled.
module disp_fetch_layer_ctr
   import disp_fetch_pkg::*;
#(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int LVL_W       = DEF_LVL_W,
   parameter int LEN_W       = DEF_LEN_W,
   parameter int FIFO_DEPTH  = 1024,
   parameter int BURST_LEN   = 64,
   parameter int FRAME_WORDS = FRAME_WORDS_1024X640
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              advance,
   input  logic              enable,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  adv_len,
   input  logic [LVL_W-1:0]  fifo_level,
   output logic [ADDR_W-1:0] addr,
   output logic [LEN_W-1:0]  burst_len,
   output logic              done,
   output logic              eligible
);

   localparam logic [LVL_W-1:0] LVL_MAX   = LVL_W'(FIFO_DEPTH - BURST_LEN);
   localparam logic [REM_W-1:0] REM_INIT  = REM_W'(FRAME_WORDS);
   localparam logic [REM_W-1:0] REM_BURST = REM_W'(BURST_LEN);

   logic [REM_W-1:0] rem;
   logic             active;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr   <= '0;
         rem    <= '0;
         active <= 1'b0;
      end else if (load) begin
         addr   <= base_addr;
         rem    <= REM_INIT;
         active <= enable;
      end else begin
         if (advance) begin
            addr <= addr + ADDR_W'(adv_len);
            rem  <= rem - REM_W'(adv_len);
         end
         if (!enable) active <= 1'b0;
      end
   end

   assign done      = !active || (rem == '0);
   assign eligible  = active && enable && (rem != '0) && (fifo_level <= LVL_MAX);
   assign burst_len = (rem >= REM_BURST) ? LEN_W'(BURST_LEN) : rem[LEN_W-1:0];

endmodule

// File: rtl/disp_fetch_arbiter.sv
// Round-robin burst fetch scheduler for the two display layer FIFOs.
// Define DISP_FETCH_STARVE_PRIO_EN to give layers below LOW_WATER strict priority.
//
// state | meaning
// IDLE  | frame fetched (or after reset), waiting for frame sync
// ARB   | pick the next eligible layer, or finish the frame
// REQ   | burst request held until rd_gnt
// WAIT  | burst in flight, waiting for rd_done
// DRAIN | restart deferred by an in-flight burst: reload and flush
module disp_fetch_arbiter
   import disp_fetch_pkg::*;
#(
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int LVL_W        = DEF_LVL_W,
   parameter int FIFO_DEPTH   = 1024,
   parameter int BURST_LEN    = 64,
   parameter int LEN_W        = DEF_LEN_W,
   parameter int FRAME_WORDS0 = FRAME_WORDS_1024X640,
   parameter int FRAME_WORDS1 = FRAME_WORDS_1024X640,
   parameter int LOW_WATER    = 128
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              frame_vs,
   input  logic [1:0]        layer_en,
   input  logic [ADDR_W-1:0] base_addr0,
   input  logic [ADDR_W-1:0] base_addr1,
   input  logic [LVL_W-1:0]  fifo_level0,
   input  logic [LVL_W-1:0]  fifo_level1,
   output logic [1:0]        fifo_flush,
   output logic              rd_req,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [LEN_W-1:0]  rd_len,
   output logic              rd_layer,
   input  logic              rd_gnt,
   input  logic              rd_done,
   output logic              frame_done
);

   if (BURST_LEN > FIFO_DEPTH / 2 || BURST_LEN >= (1 << LEN_W) || LOW_WATER > FIFO_DEPTH) begin : g_bad_cfg
      $error("disp_fetch_arbiter: inconsistent BURST_LEN / LEN_W / LOW_WATER");
   end

   fetch_state_t      state;
   logic              vs_d;
   logic              last_grant;
   logic              pending_restart;
   logic              frame_start;
   logic              load;
   logic              gnt_taken;
   logic              grant_sel;
   logic [1:0]        elig;
   logic              done0, done1;
   logic [ADDR_W-1:0] addr0, addr1;
   logic [LEN_W-1:0]  blen0, blen1;

   assign frame_start = frame_vs & ~vs_d;
   assign load        = (frame_start && (state == IDLE || state == ARB)) || (state == DRAIN);
   assign gnt_taken   = (state == REQ) && rd_req && rd_gnt;

   disp_fetch_layer_ctr #(
      .ADDR_W(ADDR_W), .LVL_W(LVL_W), .LEN_W(LEN_W), .FIFO_DEPTH(FIFO_DEPTH),
      .BURST_LEN(BURST_LEN), .FRAME_WORDS(FRAME_WORDS0)
   ) u_layer0 (
      .clk(clk), .rst_n(rst_n), .load(load), .advance(gnt_taken && !rd_layer),
      .enable(layer_en[0]), .base_addr(base_addr0), .adv_len(rd_len),
      .fifo_level(fifo_level0), .addr(addr0), .burst_len(blen0), .done(done0),
      .eligible(elig[0])
   );

   disp_fetch_layer_ctr #(
      .ADDR_W(ADDR_W), .LVL_W(LVL_W), .LEN_W(LEN_W), .FIFO_DEPTH(FIFO_DEPTH),
      .BURST_LEN(BURST_LEN), .FRAME_WORDS(FRAME_WORDS1)
   ) u_layer1 (
      .clk(clk), .rst_n(rst_n), .load(load), .advance(gnt_taken && rd_layer),
      .enable(layer_en[1]), .base_addr(base_addr1), .adv_len(rd_len),
      .fifo_level(fifo_level1), .addr(addr1), .burst_len(blen1), .done(done1),
      .eligible(elig[1])
   );

`ifdef DISP_FETCH_STARVE_PRIO_EN
   localparam logic [LVL_W-1:0] LOW_LVL = LVL_W'(LOW_WATER);
   logic [1:0] starve;
   assign starve = elig & {fifo_level1 < LOW_LVL, fifo_level0 < LOW_LVL};
`endif

   // With a single eligible layer elig[1] already names it.
   always_comb begin
      grant_sel = elig[1];
      if (&elig) grant_sel = ~last_grant;
`ifdef DISP_FETCH_STARVE_PRIO_EN
      if (starve[0])      grant_sel = 1'b0;
      else if (starve[1]) grant_sel = 1'b1;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         vs_d            <= 1'b0;
         last_grant      <= 1'b1;
         pending_restart <= 1'b0;
         fifo_flush      <= 2'b00;
         rd_req          <= 1'b0;
         rd_addr         <= '0;
         rd_len          <= '0;
         rd_layer        <= 1'b0;
         frame_done      <= 1'b0;
      end else begin
         vs_d       <= frame_vs;
         fifo_flush <= 2'b00;
         case (state)
            IDLE: begin
               if (frame_start) begin
                  fifo_flush <= 2'b11;
                  frame_done <= 1'b0;
                  state      <= ARB;
               end
            end
            ARB: begin
               if (frame_start) begin
                  fifo_flush <= 2'b11;
                  frame_done <= 1'b0;
               end else if (|elig) begin
                  rd_layer <= grant_sel;
                  rd_addr  <= grant_sel ? addr1 : addr0;
                  rd_len   <= grant_sel ? blen1 : blen0;
                  state    <= REQ;
               end else if (done0 && done1) begin
                  frame_done <= 1'b1;
                  state      <= IDLE;
               end
            end
            REQ: begin
               if (frame_start) pending_restart <= 1'b1;
               if (rd_req && rd_gnt) begin
                  rd_req     <= 1'b0;
                  last_grant <= rd_layer;
                  state      <= WAIT;
               end else begin
                  rd_req <= 1'b1;
               end
            end
            WAIT: begin
               if (frame_start) pending_restart <= 1'b1;
               if (rd_done) state <= (pending_restart || frame_start) ? DRAIN : ARB;
            end
            DRAIN: begin
               fifo_flush      <= 2'b11;
               frame_done      <= 1'b0;
               pending_restart <= 1'b0;
               state           <= ARB;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_disp_fetch_arbiter.sv
// Directed bench for disp_fetch_arbiter: reset, single-layer frame, round robin,
// level threshold, restart during a burst, starvation priority.
module tb_disp_fetch_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        frame_vs = 1'b0;
   logic [1:0]  layer_en = 2'b00;
   logic [23:0] base_addr0 = '0;
   logic [23:0] base_addr1 = '0;
   logic [10:0] fifo_level0 = '0;
   logic [10:0] fifo_level1 = '0;
   logic [1:0]  fifo_flush;
   logic        rd_req;
   logic [23:0] rd_addr;
   logic [7:0]  rd_len;
   logic        rd_layer;
   logic        rd_gnt = 1'b0;
   logic        rd_done = 1'b0;
   logic        frame_done;

   int n_cmp = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   disp_fetch_arbiter #(
      .ADDR_W(24), .LVL_W(11), .FIFO_DEPTH(1024), .BURST_LEN(64), .LEN_W(8),
      .FRAME_WORDS0(200), .FRAME_WORDS1(200), .LOW_WATER(128)
   ) dut (
      .clk(clk), .rst_n(rst_n), .frame_vs(frame_vs), .layer_en(layer_en),
      .base_addr0(base_addr0), .base_addr1(base_addr1),
      .fifo_level0(fifo_level0), .fifo_level1(fifo_level1),
      .fifo_flush(fifo_flush), .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len),
      .rd_layer(rd_layer), .rd_gnt(rd_gnt), .rd_done(rd_done), .frame_done(frame_done)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      frame_vs = 1'b0;
      rd_gnt = 1'b0;
      rd_done = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic start_frame();
      frame_vs = 1'b1;
      tick();
      frame_vs = 1'b0;
   endtask

   task automatic wait_req(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (rd_req === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Memory-controller stand-in: grant one cycle after rd_req, rd_done a few cycles later.
   task automatic serve(output bit ok, output logic lay, output logic [23:0] a, output logic [7:0] l);
      wait_req(ok);
      lay = rd_layer;
      a = rd_addr;
      l = rd_len;
      if (!ok) return;
      @(posedge clk); #1 rd_gnt = 1'b1;
      @(posedge clk); #1 rd_gnt = 1'b0;
      repeat (4) @(posedge clk);
      #1 rd_done = 1'b1;
      @(posedge clk); #1 rd_done = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      n_cmp++;
      if ({rd_req, rd_layer, frame_done, fifo_flush} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: rd_req=%0d rd_layer=%0d frame_done=%0d fifo_flush=%b, want all 0",
                  rd_req, rd_layer, frame_done, fifo_flush);
      end
      n_cmp++;
      if ({rd_addr, rd_len} !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_bus: rd_addr=%h rd_len=%0d, want 0/0", rd_addr, rd_len);
      end
      do_reset();
   endtask

   task automatic test_single_layer();
      bit ok;
      logic lay;
      logic [23:0] a;
      logic [7:0] l;
      int exp_len [4] = '{64, 64, 64, 8};
      int exp_off [4] = '{0, 64, 128, 192};
      do_reset();
      layer_en = 2'b01;
      fifo_level0 = 11'd0;
      fifo_level1 = 11'd0;
      base_addr0 = 24'h10_0000;
      base_addr1 = 24'h20_0000;
      start_frame();
      @(negedge clk);
      n_cmp++;
      if (fifo_flush !== 2'b11 || rd_req !== 1'b0) begin
         n_fail++;
         $display("FAIL single_flush: fifo_flush=%b rd_req=%0d, want 11/0", fifo_flush, rd_req);
      end
      @(negedge clk);
      n_cmp++;
      if (fifo_flush !== 2'b00 || rd_req !== 1'b0) begin
         n_fail++;
         $display("FAIL single_flush_end: fifo_flush=%b rd_req=%0d, want 00/0", fifo_flush, rd_req);
      end
      @(negedge clk);
      n_cmp++;
      if (rd_req !== 1'b1) begin
         n_fail++;
         $display("FAIL single_latency: rd_req=%0d two cycles after flush, want 1", rd_req);
      end
      for (int i = 0; i < 4; i++) begin
         serve(ok, lay, a, l);
         n_cmp++;
         if (!ok || lay !== 1'b0 || a !== base_addr0 + 24'(exp_off[i]) || l !== 8'(exp_len[i])) begin
            n_fail++;
            $display("FAIL single_burst%0d: ok=%0d layer=%0d addr=%h len=%0d, want layer=0 addr=%h len=%0d",
                     i, ok, lay, a, l, base_addr0 + 24'(exp_off[i]), exp_len[i]);
         end
      end
      repeat (3) @(negedge clk);
      n_cmp++;
      if (frame_done !== 1'b1 || rd_req !== 1'b0) begin
         n_fail++;
         $display("FAIL single_frame_done: frame_done=%0d rd_req=%0d, want 1/0", frame_done, rd_req);
      end
      tick();
      start_frame();
      @(negedge clk);
      n_cmp++;
      if (frame_done !== 1'b0 || fifo_flush !== 2'b11) begin
         n_fail++;
         $display("FAIL single_next_frame: frame_done=%0d fifo_flush=%b, want 0/11", frame_done, fifo_flush);
      end
   endtask

   task automatic test_round_robin();
      bit ok;
      logic lay;
      logic [23:0] a;
      logic [7:0] l;
      logic exp_lay [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic [23:0] exp_addr [4] = '{24'h10_0000, 24'hFF_FFC0, 24'h10_0040, 24'h00_0000};
      do_reset();
      layer_en = 2'b11;
      fifo_level0 = 11'd0;
      fifo_level1 = 11'd0;
      base_addr0 = 24'h10_0000;
      base_addr1 = 24'hFF_FFC0;
      start_frame();
      for (int i = 0; i < 4; i++) begin
         serve(ok, lay, a, l);
         n_cmp++;
         if (!ok || lay !== exp_lay[i] || a !== exp_addr[i] || l !== 8'd64) begin
            n_fail++;
            $display("FAIL rr_burst%0d: ok=%0d layer=%0d addr=%h len=%0d, want layer=%0d addr=%h len=64",
                     i, ok, lay, a, l, exp_lay[i], exp_addr[i]);
         end
      end
   endtask

   task automatic test_level_threshold();
      bit ok;
      logic lay;
      logic [23:0] a;
      logic [7:0] l;
      do_reset();
      layer_en = 2'b11;
      fifo_level0 = 11'd0;
      fifo_level1 = 11'd961;
      base_addr0 = 24'h00_1000;
      base_addr1 = 24'h00_8000;
      start_frame();
      for (int i = 0; i < 2; i++) begin
         serve(ok, lay, a, l);
         n_cmp++;
         if (!ok || lay !== 1'b0 || a !== 24'h00_1000 + 24'(64 * i)) begin
            n_fail++;
            $display("FAIL level_withheld%0d: ok=%0d layer=%0d addr=%h, want layer=0 addr=%h",
                     i, ok, lay, a, 24'h00_1000 + 24'(64 * i));
         end
      end
      fifo_level1 = 11'd960;
      serve(ok, lay, a, l);
      n_cmp++;
      if (!ok || lay !== 1'b1 || a !== 24'h00_8000 || l !== 8'd64) begin
         n_fail++;
         $display("FAIL level_released: ok=%0d layer=%0d addr=%h len=%0d, want layer=1 addr=008000 len=64",
                  ok, lay, a, l);
      end
   endtask

   task automatic test_restart_in_wait();
      bit ok;
      logic lay;
      logic [23:0] a;
      logic [7:0] l;
      do_reset();
      layer_en = 2'b01;
      fifo_level0 = 11'd0;
      fifo_level1 = 11'd0;
      base_addr0 = 24'h12_3400;
      start_frame();
      wait_req(ok);
      n_cmp++;
      if (!ok || rd_addr !== 24'h12_3400) begin
         n_fail++;
         $display("FAIL restart_first: ok=%0d addr=%h, want 123400", ok, rd_addr);
      end
      tick();
      rd_gnt = 1'b1;
      tick();
      rd_gnt = 1'b0;
      frame_vs = 1'b1;
      tick();
      frame_vs = 1'b0;
      tick();
      tick();
      @(negedge clk);
      n_cmp++;
      if (fifo_flush !== 2'b00 || rd_req !== 1'b0) begin
         n_fail++;
         $display("FAIL restart_hold: fifo_flush=%b rd_req=%0d during burst, want 00/0", fifo_flush, rd_req);
      end
      rd_done = 1'b1;
      @(posedge clk); #1 rd_done = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (fifo_flush !== 2'b00) begin
         n_fail++;
         $display("FAIL restart_drain: fifo_flush=%b on DRAIN entry, want 00", fifo_flush);
      end
      @(negedge clk);
      n_cmp++;
      if (fifo_flush !== 2'b11 || rd_req !== 1'b0) begin
         n_fail++;
         $display("FAIL restart_flush: fifo_flush=%b rd_req=%0d, want 11/0", fifo_flush, rd_req);
      end
      @(negedge clk);
      n_cmp++;
      if (fifo_flush !== 2'b00) begin
         n_fail++;
         $display("FAIL restart_flush_len: fifo_flush=%b, want 00", fifo_flush);
      end
      serve(ok, lay, a, l);
      n_cmp++;
      if (!ok || lay !== 1'b0 || a !== 24'h12_3400 || l !== 8'd64) begin
         n_fail++;
         $display("FAIL restart_addr: ok=%0d layer=%0d addr=%h len=%0d, want layer=0 addr=123400 len=64",
                  ok, lay, a, l);
      end
   endtask

   task automatic test_starve_prio();
      bit ok;
      logic lay;
      logic [23:0] a;
      logic [7:0] l;
`ifdef DISP_FETCH_STARVE_PRIO_EN
      logic exp_lay [2] = '{1'b1, 1'b1};
      logic [23:0] exp_addr [2] = '{24'h00_8000, 24'h00_8040};
`else
      logic exp_lay [2] = '{1'b0, 1'b1};
      logic [23:0] exp_addr [2] = '{24'h00_1000, 24'h00_8000};
`endif
      do_reset();
      layer_en = 2'b11;
      fifo_level0 = 11'd200;
      fifo_level1 = 11'd50;
      base_addr0 = 24'h00_1000;
      base_addr1 = 24'h00_8000;
      start_frame();
      for (int i = 0; i < 2; i++) begin
         serve(ok, lay, a, l);
         n_cmp++;
         if (!ok || lay !== exp_lay[i] || a !== exp_addr[i]) begin
            n_fail++;
            $display("FAIL starve_burst%0d: ok=%0d layer=%0d addr=%h, want layer=%0d addr=%h",
                     i, ok, lay, a, exp_lay[i], exp_addr[i]);
         end
      end
   endtask

   task automatic test_reset_mid_wait();
      bit ok;
      int seen;
      do_reset();
      layer_en = 2'b01;
      fifo_level0 = 11'd0;
      base_addr0 = 24'h00_0ABC;
      start_frame();
      wait_req(ok);
      tick();
      rd_gnt = 1'b1;
      tick();
      rd_gnt = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({rd_req, rd_layer, frame_done, fifo_flush} !== 5'b0 || {rd_addr, rd_len} !== 32'h0) begin
         n_fail++;
         $display("FAIL midwait_reset: rd_req=%0d addr=%h len=%0d layer=%0d flush=%b done=%0d, want all 0",
                  rd_req, rd_addr, rd_len, rd_layer, fifo_flush, frame_done);
      end
      tick();
      tick();
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (rd_req !== 1'b0 || fifo_flush !== 2'b00) seen++;
      end
      n_cmp++;
      if (seen !== 0) begin
         n_fail++;
         $display("FAIL midwait_idle: %0d cycles with rd_req/fifo_flush active without frame_vs, want 0", seen);
      end
      tick();
      start_frame();
      wait_req(ok);
      n_cmp++;
      if (!ok || rd_addr !== 24'h00_0ABC || rd_len !== 8'd64) begin
         n_fail++;
         $display("FAIL midwait_restart: ok=%0d addr=%h len=%0d, want 000abc/64", ok, rd_addr, rd_len);
      end
   endtask

   initial begin
      test_reset();
      test_single_layer();
      test_round_robin();
      test_level_threshold();
      test_restart_in_wait();
      test_starve_prio();
      test_reset_mid_wait();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/disp_fetch_arbiter.md
Name: disp_fetch_arbiter

Overview:
- Schedules burst reads from the shared frame-buffer read port into two per-layer display line FIFOs: layer 0 is the camera/background and layer 1 is the overlay.
- Sits between the LCD timing driver (frame_vs) and the memory read controller.
- Restarts both layer address streams on every frame sync and keeps each FIFO topped up with round-robin arbitration.

Parameters:
- ADDR_W, 24, read address width in words
- LVL_W, 11, FIFO fill-level width
- FIFO_DEPTH, 1024, words per layer FIFO
- BURST_LEN, 64, maximum words per read burst (power of two, at most FIFO_DEPTH/2)
- LEN_W, 8, width of rd_len (must hold BURST_LEN)
- FRAME_WORDS0, 655360, words per frame for layer 0 (1024x640)
- FRAME_WORDS1, 655360, words per frame for layer 1
- LOW_WATER, 128, starvation threshold used only when the optional feature is compiled in

Ports:
- clk  in  1  pixel/system clock
- rst_n  in  1  asynchronous active-low reset
- frame_vs  in  1  vertical sync from the timing driver, active high
- layer_en  in  2  per-layer fetch enable; bit i enables layer i
- base_addr0  in  ADDR_W  layer 0 frame base address
- base_addr1  in  ADDR_W  layer 1 frame base address
- fifo_level0  in  LVL_W  layer 0 FIFO fill level
- fifo_level1  in  LVL_W  layer 1 FIFO fill level
- fifo_flush  out  2  one-cycle flush pulse per layer FIFO
- rd_req  out  1  burst read request
- rd_addr  out  ADDR_W  burst start address
- rd_len  out  LEN_W  burst length in words
- rd_layer  out  1  destination layer of the current burst
- rd_gnt  in  1  request accepted by the memory controller
- rd_done  in  1  last word of the burst has been written into the FIFO
- frame_done  out  1  both enabled layers completely fetched for this frame

Behaviour:
- Clock and reset: clk is the clock. rst_n is asynchronous, active-low.
- Reset values:
  - fifo_flush=0, rd_req=0, rd_addr=0, rd_len=0, rd_layer=0, frame_done=0.
  - State=IDLE, addr_i=0, rem_i=0, last_grant=1, vs_d=0.
- Frame start: frame_start = frame_vs & ~vs_d, where vs_d is frame_vs registered.
  - In IDLE or ARB, on frame_start load addr_i=base_addr_i and rem_i=FRAME_WORDSi for both layers.
  - Registered outputs on the next cycle: fifo_flush=2'b11 for exactly one cycle, frame_done=0, state=ARB.
- States: IDLE, ARB, REQ, WAIT, DRAIN.
- IDLE: wait for frame_start.
- ARB:
  - Layer i is eligible when layer_en[i]=1, rem_i != 0 and fifo_level_i <= FIFO_DEPTH-BURST_LEN.
  - If both layers are eligible, grant the one that is not last_grant.
  - If exactly one is eligible, grant it.
  - If none is eligible, stay in ARB. When every enabled layer has rem=0, set frame_done=1 and go to IDLE.
  - On a grant, register rd_layer, rd_addr=addr_g and rd_len=min(BURST_LEN, rem_g), then go to REQ.
- REQ:
  - rd_req=1; rd_addr, rd_len and rd_layer are held stable.
  - On rd_gnt: rd_req=0 the next cycle, addr_g+=rd_len, rem_g-=rd_len, last_grant=g, go to WAIT.
  - rd_done is ignored in REQ.
- WAIT: on rd_done, go to ARB.
- Frame start in REQ or WAIT:
  - Latch a pending_restart flag.
  - A request is never withdrawn; an accepted burst is never aborted.
  - From REQ, complete the grant and go to WAIT.
  - When rd_done arrives with pending_restart set, go to DRAIN instead of ARB.
  - DRAIN performs the frame-start load, pulses fifo_flush=2'b11, clears pending_restart, then goes to ARB.
- Arithmetic:
  - rem_i is 24 bits wide; rd_len is zero-extended when subtracted.
  - Address increments wrap modulo 2^ADDR_W.
- Disabled layers:
  - A layer disabled mid-frame is skipped until the next frame.
  - A burst already in flight for that layer completes normally.
- Latency: the first rd_req is asserted 2 cycles after the flush pulse at the earliest.
- Simultaneous frame_start and rd_done in WAIT: treated as pending, so the FSM takes the DRAIN path.

Optional Feature:
- Macro: DISP_FETCH_STARVE_PRIO_EN.
- Defined: in ARB, an eligible layer with fifo_level < LOW_WATER wins strict priority over round-robin. If both layers are starving, layer 0 wins. last_grant is still updated.
- Undefined: pure round-robin; LOW_WATER is unused.

Decomposition:
- Shared package disp_fetch_pkg holds:
  - the state encoding (IDLE, ARB, REQ, WAIT, DRAIN)
  - the default widths (ADDR_W, LVL_W, LEN_W)
  - the frame-word constants for 1024x640.
- One sub-module: disp_fetch_layer_ctr, instantiated once per layer.
  - Holds the per-layer addr/rem counters with load, advance and rem==0 flag.
  - Computes eligibility.

Test Plan:
- Reset mid-WAIT, then release → all outputs are 0, state is IDLE, and no rd_req until a frame_vs rising edge.
- FRAME_WORDS0=200, only layer 0 enabled, levels=0, rd_gnt one cycle after rd_req, rd_done 5 cycles later → bursts at base_addr0 with lengths 64,64,64,8; addresses base, +64, +128, +192; frame_done=1 afterwards.
- Both layers enabled, both levels=0 → grants alternate starting with layer 0 (last_grant reset to 1): rd_layer sequence 0,1,0,1.
- fifo_level1=961 (above 1024-64=960), level0=0 → only layer 1 is withheld. Then drop level1 to 960 → layer 1 is granted on the next ARB.
- frame_vs edge during WAIT → the burst completes, then fifo_flush=2'b11 for one cycle. The next rd_addr equals base_addr0 again, with no request from the old frame after the flush.
- With DISP_FETCH_STARVE_PRIO_EN, last_grant=1, level0=200, level1=50 → layer 1 is granted twice in a row. Without the macro → layer 0 is granted.
